uart_rx_fifo_ext: RTL and testbench

Parametrised receive FIFO for the APB UART, sitting between the RX deserialiser and the APB register file. It generalises the 8-bit/16-deep RX FIFO:
- width and depth are parametrised
- a per-character error tag (parity/framing/break) is stored with each entry
- the trigger threshold is programmable
- push and pop are accepted together when full
- overrun is sticky, and an error-pending summary is provided
- an optional character-timeout detector is included (16550-style).

---
 rtl/uart_rx_fifo_ext.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_fifo_ext.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ext.sv
// uart_rx_fifo_ext: receive FIFO for the APB UART.
// Stores each received character together with its {break, framing, parity}
// tag, presents the head entry first-word fall-through, and reports trigger,
// sticky overrun, error-pending and (optionally) character-timeout status.
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN builds the idle-timeout
// counter; without it fifo_rx_timeout_o is tied low.
module uart_rx_fifo_ext #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT_W = 16,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fifo_rx_reset_i,
    input  logic [DATA_W-1:0]    fifo_rx_i,
    input  logic [2:0]           fifo_rx_err_i,
    input  logic                 fifo_rx_push_i,
    input  logic                 fifo_rx_pop_i,
    input  logic [PTR_W:0]       fifo_rx_trig_level_i,
    input  logic [TIMEOUT_W-1:0] fifo_rx_timeout_cycles_i,
    input  logic                 fifo_rx_overrun_clr_i,
    output logic [DATA_W-1:0]    fifo_rx_o,
    output logic [2:0]           fifo_rx_err_o,
    output logic [PTR_W:0]       fifo_rx_count_o,
    output logic                 fifo_rx_empty_o,
    output logic                 fifo_rx_full_o,
    output logic                 fifo_rx_triggered_o,
    output logic                 fifo_rx_overrun_o,
    output logic                 fifo_rx_err_pending_o,
    output logic                 fifo_rx_timeout_o
);

    localparam int ENT_W = DATA_W + 3;
    localparam logic [PTR_W:0]   ZERO_C  = (PTR_W+1)'(0);
    localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PINC_C  = PTR_W'(1);

    // A stored tag counts as an error when any of its three bits is set.
    function automatic logic tag_nonzero(input logic [2:0] tag);
        return |tag;
    endfunction

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   errcnt_r;
    logic             overrun_r;

    logic             empty_s;
    logic             full_s;
    logic             push_acc_s;
    logic             pop_acc_s;
    logic             drop_s;
    logic             err_in_s;
    logic             err_out_s;
    logic [ENT_W-1:0] head_s;
    logic [PTR_W:0]   trig_eff_s;

    // Handshake decode: a full FIFO still accepts a push when a pop frees the slot.
    always_comb begin
        empty_s    = (count_r == ZERO_C);
        full_s     = (count_r == DEPTH_C);
        head_s     = mem_r[rd_ptr_r];
        push_acc_s = fifo_rx_push_i & (~full_s | fifo_rx_pop_i);
        pop_acc_s  = fifo_rx_pop_i & ~empty_s;
        drop_s     = fifo_rx_push_i & full_s & ~fifo_rx_pop_i;
        err_in_s   = push_acc_s & tag_nonzero(fifo_rx_err_i);
        err_out_s  = pop_acc_s & tag_nonzero(head_s[DATA_W +: 3]);
        if (fifo_rx_trig_level_i == ZERO_C) begin
            trig_eff_s = ONE_C;
        end else begin
            trig_eff_s = fifo_rx_trig_level_i;
        end
    end

    // Entry storage is deliberately not reset; pointers make stale data unreachable.
    always_ff @(posedge clk) begin
        if (reset_n && !fifo_rx_reset_i && push_acc_s) begin
            mem_r[wr_ptr_r] <= {fifo_rx_err_i, fifo_rx_i};
        end
    end

    // Pointer, occupancy and error-count bookkeeping; flush overrides any transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= ZERO_C;
            errcnt_r <= ZERO_C;
        end else if (fifo_rx_reset_i) begin
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= ZERO_C;
            errcnt_r <= ZERO_C;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PINC_C;
            end
            if (pop_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PINC_C;
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            case ({err_in_s, err_out_s})
                2'b10:   errcnt_r <= errcnt_r + ONE_C;
                2'b01:   errcnt_r <= errcnt_r - ONE_C;
                default: errcnt_r <= errcnt_r;
            endcase
        end
    end

    // Sticky overrun: a dropped push beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
        end else if (fifo_rx_reset_i) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (fifo_rx_overrun_clr_i) begin
            overrun_r <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tcnt_r;

    // Idle-cycle counter: restarts on any transfer or while empty, saturates at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_r <= TIMEOUT_W'(0);
        end else if (fifo_rx_reset_i || push_acc_s || pop_acc_s || empty_s) begin
            tcnt_r <= TIMEOUT_W'(0);
        end else if (tcnt_r != {TIMEOUT_W{1'b1}}) begin
            tcnt_r <= tcnt_r + TIMEOUT_W'(1);
        end
    end

    assign fifo_rx_timeout_o = ~empty_s & (fifo_rx_timeout_cycles_i != TIMEOUT_W'(0))
                               & (tcnt_r >= fifo_rx_timeout_cycles_i);
`else
    logic unused_timeout_s;
    assign unused_timeout_s  = ^fifo_rx_timeout_cycles_i;
    assign fifo_rx_timeout_o = 1'b0;
`endif

    assign fifo_rx_o             = head_s[DATA_W-1:0];
    assign fifo_rx_err_o         = head_s[DATA_W +: 3];
    assign fifo_rx_count_o       = count_r;
    assign fifo_rx_empty_o       = empty_s;
    assign fifo_rx_full_o        = full_s;
    assign fifo_rx_triggered_o   = (count_r >= trig_eff_s);
    assign fifo_rx_overrun_o     = overrun_r;
    assign fifo_rx_err_pending_o = (errcnt_r != ZERO_C);

endmodule

// File: tb/tb_uart_rx_fifo_ext.sv
// Self-checking bench for uart_rx_fifo_ext (DATA_W=8, DEPTH=16, TIMEOUT_W=16).
module tb_uart_rx_fifo_ext;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [7:0]  din;
    logic [2:0]  ein;
    logic        push;
    logic        pop;
    logic [4:0]  trig;
    logic [15:0] tcyc;
    logic        oclr;
    logic [7:0]  dout;
    logic [2:0]  eout;
    logic [4:0]  count;
    logic        empty, full, trg, ovr, errp, tout;

    int n_pass = 0;
    int n_chk  = 0;

    uart_rx_fifo_ext dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .fifo_rx_reset_i          (flush),
        .fifo_rx_i                (din),
        .fifo_rx_err_i            (ein),
        .fifo_rx_push_i           (push),
        .fifo_rx_pop_i            (pop),
        .fifo_rx_trig_level_i     (trig),
        .fifo_rx_timeout_cycles_i (tcyc),
        .fifo_rx_overrun_clr_i    (oclr),
        .fifo_rx_o                (dout),
        .fifo_rx_err_o            (eout),
        .fifo_rx_count_o          (count),
        .fifo_rx_empty_o          (empty),
        .fifo_rx_full_o           (full),
        .fifo_rx_triggered_o      (trg),
        .fifo_rx_overrun_o        (ovr),
        .fifo_rx_err_pending_o    (errp),
        .fifo_rx_timeout_o        (tout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push, pop, flush;
        logic [7:0] d;
        logic [2:0] e;
        logic [4:0] trig;
        logic [4:0] cnt;
        logic       empty, full, trg, errp;
        logic [7:0] head;
        logic [2:0] herr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic p, input logic q, input logic [7:0] d,
                        input logic [2:0] e, input logic f, input logic c);
        @(negedge clk);
        push = p; pop = q; din = d; ein = e; flush = f; oclr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; din = 8'h00; ein = 3'b000;
        push = 1'b0; pop = 1'b0; trig = 5'd4; tcyc = 16'd10; oclr = 1'b0;

        //          push  pop   flush d      e       trig  cnt   emp   full  trg   errp  head   herr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h41, 3'b000, 5'd4,  5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 3'b000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h42, 3'b010, 5'd4,  5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 3'b000};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h43, 3'b000, 5'd4,  5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41, 3'b000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h44, 3'b000, 5'd4,  5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 3'b000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 5'd4,  5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 3'b010};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 5'd4,  5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h43, 3'b000};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 5'd0,  5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h43, 3'b000};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 5'd0,  5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 3'b000};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h45, 3'b100, 5'd0,  5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h45, 3'b100};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 5'd0,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h46, 3'b001, 5'd0,  5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h46, 3'b001};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 5'd17, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h46, 3'b001};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h47, 3'b000, 5'd17, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst count", count, 32'd0);
        chk("rst empty", empty, 32'd1);
        chk("rst full", full, 32'd0);
        chk("rst trig", trg, 32'd0);
        chk("rst ovr", ovr, 32'd0);
        chk("rst errp", errp, 32'd0);
        chk("rst tout", tout, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven vectors: errors, trigger levels, empty push+pop, flush
        for (int i = 0; i < 13; i++) begin
            trig = vecs[i].trig;
            step(vecs[i].push, vecs[i].pop, vecs[i].d, vecs[i].e, vecs[i].flush, 1'b0);
            chk($sformatf("vec%0d count", i), count, vecs[i].cnt);
            chk($sformatf("vec%0d empty", i), empty, vecs[i].empty);
            chk($sformatf("vec%0d full", i), full, vecs[i].full);
            chk($sformatf("vec%0d trig", i), trg, vecs[i].trg);
            chk($sformatf("vec%0d errp", i), errp, vecs[i].errp);
            if (!vecs[i].empty) begin
                chk($sformatf("vec%0d head", i), dout, vecs[i].head);
                chk($sformatf("vec%0d herr", i), eout, vecs[i].herr);
            end
        end
        trig = 5'd4;

        // Offset the pointers by one so each fill wraps mid-way
        step(1'b1, 1'b0, 8'hFF, 3'b000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);

        // Fill/drain, three rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                step(1'b1, 1'b0, 8'(i), 3'b000, 1'b0, 1'b0);
            end
            chk($sformatf("fill%0d full", r), full, 32'd1);
            chk($sformatf("fill%0d count", r), count, 32'd16);
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("drain%0d head%0d", r, i), dout, 32'(i));
                step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
            end
            chk($sformatf("drain%0d empty", r), empty, 32'd1);
        end

        // Overrun and full push+pop
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(8'h10 + i), 3'b000, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 8'hAA, 3'b111, 1'b0, 1'b0);
        chk("ovr drop count", count, 32'd16);
        chk("ovr set", ovr, 32'd1);
        chk("ovr drop errp", errp, 32'd0);
        chk("ovr drop head", dout, 32'h10);
        step(1'b1, 1'b1, 8'hBB, 3'b000, 1'b0, 1'b0);
        chk("fullpp count", count, 32'd16);
        chk("fullpp ovr", ovr, 32'd1);
        chk("fullpp head", dout, 32'h11);
        step(1'b1, 1'b0, 8'hCC, 3'b000, 1'b0, 1'b1);
        chk("ovr set beats clr", ovr, 32'd1);
        step(1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
        chk("ovr clr", ovr, 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("ovr drain head%0d", i), dout, 32'(8'h10 + i));
            step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
        end
        chk("ovr last BB", dout, 32'hBB);
        step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
        chk("ovr drain empty", empty, 32'd1);

        // Character timeout with 10 idle cycles
        step(1'b1, 1'b0, 8'h55, 3'b000, 1'b0, 1'b0);
        chk("tout after push", tout, 32'd0);
        for (int k = 1; k <= 11; k++) begin
            step(1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_TIMEOUT_EN
            chk($sformatf("tout idle%0d", k), tout, (k >= 10) ? 32'd1 : 32'd0);
`else
            chk($sformatf("tout idle%0d", k), tout, 32'd0);
`endif
        end
        step(1'b0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
        chk("tout pop clears", tout, 32'd0);
        repeat (12) step(1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        chk("tout empty idle", tout, 32'd0);

        // Flush with 5 entries held and a simultaneous push
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'(8'h60 + i), (i == 2) ? 3'b010 : 3'b000, 1'b0, 1'b0);
        end
        chk("pre-flush count", count, 32'd5);
        chk("pre-flush errp", errp, 32'd1);
        step(1'b1, 1'b0, 8'h99, 3'b100, 1'b1, 1'b0);
        chk("flush count", count, 32'd0);
        chk("flush empty", empty, 32'd1);
        chk("flush errp", errp, 32'd0);
        step(1'b1, 1'b0, 8'h77, 3'b000, 1'b0, 1'b0);
        chk("post-flush head", dout, 32'h77);
        chk("post-flush count", count, 32'd1);

        // Asynchronous reset mid-stream with everything asserted
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 8'(i), 3'b001, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 8'hEE, 3'b000, 1'b0, 1'b0);
        chk("pre-rst full", full, 32'd1);
        chk("pre-rst ovr", ovr, 32'd1);
        chk("pre-rst errp", errp, 32'd1);
        @(negedge clk);
        push = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst count", count, 32'd0);
        chk("arst empty", empty, 32'd1);
        chk("arst full", full, 32'd0);
        chk("arst trig", trg, 32'd0);
        chk("arst ovr", ovr, 32'd0);
        chk("arst errp", errp, 32'd0);
        chk("arst tout", tout, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 8'h12, 3'b000, 1'b0, 1'b0);
        chk("post-rst head", dout, 32'h12);
        chk("post-rst count", count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
